// File: rtl/ixc_ev_sched_if.sv
// Event scheduler bus: event capture inputs, emulator stop/ack handshake,
// and the grant/pending/overflow status outputs. master = host side, slave = scheduler.
interface ixc_ev_sched_if #(
  parameter int NUM_EV = 4,
  parameter int ID_W   = 2
);
  logic              enable;
  logic [NUM_EV-1:0] ev_req;
  logic              stop_done;
  logic              emu_ack;
  logic              ovf_clr;
  logic              stop_req;
  logic              ev_valid;
  logic [ID_W-1:0]   ev_id;
  logic [NUM_EV-1:0] pend;
  logic [NUM_EV-1:0] ovf;

  modport master (
    output enable, ev_req, stop_done, emu_ack, ovf_clr,
    input  stop_req, ev_valid, ev_id, pend, ovf
  );

  modport slave (
    input  enable, ev_req, stop_done, emu_ack, ovf_clr,
    output stop_req, ev_valid, ev_id, pend, ovf
  );
endinterface

// File: rtl/ixc_ev_sched.sv
// Round-robin event scheduler: captures event pulses, halts the emulator,
// presents one event for host service. Ports: clk, rst (async high), io_if (slave).
module ixc_ev_sched #(
  parameter int NUM_EV = 4,
  parameter int ID_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  ixc_ev_sched_if.slave   io_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STOP,
    S_WAIT,
    S_REL
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [NUM_EV-1:0] r_pend;
  logic [NUM_EV-1:0] r_ovf;
  logic [NUM_EV-1:0] w_set;
  logic [NUM_EV-1:0] w_clr;
  logic [NUM_EV-1:0] w_ovf_set;
  logic [ID_W-1:0]   r_ev_id;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_gnt_vld;
  logic              r_stop;
  logic              r_valid;

  // Scan from the highest offset down so the
  // nearest set bit above rr_ptr is written last.
  always_comb begin : rr_pick
    logic [ID_W-1:0] idx;
    idx       = '0;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = NUM_EV - 1; k >= 0; k--) begin
      idx = ID_W'((int'(r_rr_ptr) + k) % NUM_EV);
      if (r_pend[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = idx;
      end
    end
  end

  always_comb begin : fsm_nxt
    w_nxt = r_state;
    w_clr = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_nxt = S_STOP;
          w_clr = NUM_EV'(1) << w_gnt_id;
        end
      end
      S_STOP: begin
        if (io_if.stop_done) w_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io_if.emu_ack) w_nxt = S_REL;
      end
      S_REL: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  assign w_set     = io_if.enable ? io_if.ev_req : '0;
  // A grant clearing the same bit is not an overflow; the set re-queues it.
  assign w_ovf_set = w_set & r_pend & ~w_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= '0;
      r_ovf    <= '0;
      r_ev_id  <= '0;
      r_rr_ptr <= '0;
      r_stop   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      r_ovf  <= (io_if.ovf_clr ? '0 : r_ovf) | w_ovf_set;
      if (r_state == S_IDLE && w_gnt_vld) begin
        r_ev_id <= w_gnt_id;
      end
      if (r_state == S_REL) begin
        r_rr_ptr <= (r_ev_id == ID_W'(NUM_EV - 1)) ?
                    '0 : r_ev_id + 1'b1;
      end
      // Outputs are flopped state decodes, one cycle behind the state.
      r_stop  <= (r_state == S_STOP) || (r_state == S_WAIT);
      r_valid <= (r_state == S_WAIT);
    end
  end

  assign io_if.stop_req = r_stop;
  assign io_if.ev_valid = r_valid;
  assign io_if.ev_id    = r_ev_id;
  assign io_if.pend     = r_pend;
  assign io_if.ovf      = r_ovf;

endmodule

// File: tb/tb_ixc_ev_sched.sv
// Testbench for ixc_ev_sched: directed scenarios plus random traffic,
// checked every cycle against an event-level reference model.
module tb_ixc_ev_sched;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ixc_ev_sched_if #(.NUM_EV(N), .ID_W(2)) bus ();

  ixc_ev_sched #(.NUM_EV(N), .ID_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  int m_pend, m_ovf, m_id, m_ptr;
  bit m_busy, m_done, m_rel, m_stop, m_valid;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
    m_busy = 0; m_done = 0; m_rel = 0;
    m_stop = 0; m_valid = 0;
  endtask

  task automatic model_step(input bit en, input int req,
                            input bit sd, input bit ack, input bit clr);
    int  clr_m, set, os, g;
    bit  gnt, nstop, nvalid;
    clr_m  = 0;
    gnt    = 0;
    g      = 0;
    nstop  = m_busy && !m_rel;
    nvalid = m_busy && m_done && !m_rel;
    if (!m_busy && m_pend != 0) begin
      for (int k = 0; k < N; k++) begin
        if (!gnt && (((m_pend >> ((m_ptr + k) % N)) & 1) == 1)) begin
          gnt = 1;
          g   = (m_ptr + k) % N;
        end
      end
      clr_m = 1 << g;
    end
    set    = en ? req : 0;
    os     = set & m_pend & ~clr_m & 15;
    m_pend = ((m_pend & ~clr_m) | set) & 15;
    m_ovf  = (clr ? 0 : m_ovf) | os;
    if (!m_busy) begin
      if (gnt) begin
        m_busy = 1; m_done = 0; m_rel = 0; m_id = g;
      end
    end else if (m_rel) begin
      m_busy = 0; m_done = 0; m_rel = 0;
      m_ptr  = (m_id + 1) % N;
    end else if (!m_done) begin
      if (sd) m_done = 1;
    end else if (ack) begin
      m_rel = 1;
    end
    m_stop  = nstop;
    m_valid = nvalid;
  endtask

  task automatic compare_all();
    chk("stop_req", 32'(bus.stop_req), 32'(m_stop));
    chk("ev_valid", 32'(bus.ev_valid), 32'(m_valid));
    chk("ev_id", 32'(bus.ev_id), 32'(m_id));
    chk("pend", 32'(bus.pend), 32'(m_pend));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask

  task automatic cyc(input bit en, input logic [3:0] req,
                     input bit sd, input bit ack, input bit clr);
    @(negedge clk);
    bus.enable    = en;
    bus.ev_req    = req;
    bus.stop_done = sd;
    bus.emu_ack   = ack;
    bus.ovf_clr   = clr;
    model_step(en, int'(req), sd, ack, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.ev_req    = '0;
    bus.stop_done = 1'b0;
    bus.emu_ack   = 1'b0;
    bus.ovf_clr   = 1'b0;
    model_reset();
    #1;
    chk("rst_stop", 32'(bus.stop_req), 0);
    chk("rst_valid", 32'(bus.ev_valid), 0);
    chk("rst_id", 32'(bus.ev_id), 0);
    chk("rst_pend", 32'(bus.pend), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic to_valid();
    int n;
    n = 0;
    while (!bus.stop_req && n < 20) begin
      cyc(1, 4'b0000, 0, 0, 0);
      n++;
    end
    chk("wait_stop", 32'(bus.stop_req), 1);
    cyc(1, 4'b0000, 1, 0, 0);
    n = 0;
    while (!bus.ev_valid && n < 20) begin
      cyc(1, 4'b0000, 0, 0, 0);
      n++;
    end
    chk("wait_valid", 32'(bus.ev_valid), 1);
  endtask

  task automatic finish_grant();
    cyc(1, 4'b0000, 0, 1, 0);
    cyc(1, 4'b0000, 0, 0, 0);
  endtask

  task automatic serve(output int id);
    to_valid();
    id = int'(bus.ev_id);
    finish_grant();
  endtask

  initial begin
    int id;
    logic [3:0] rq;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.ev_req    = '0;
    bus.stop_done = 1'b0;
    bus.emu_ack   = 1'b0;
    bus.ovf_clr   = 1'b0;
    model_reset();

    // single event with fixed handshake timing
    do_reset();
    cyc(1, 4'b0100, 0, 0, 0);
    chk("s1_pend", 32'(bus.pend), 32'h4);
    cyc(1, 4'b0000, 0, 0, 0);
    chk("s1_lat1", 32'(bus.stop_req), 0);
    cyc(1, 4'b0000, 0, 0, 0);
    chk("s1_lat2", 32'(bus.stop_req), 1);
    chk("s1_id", 32'(bus.ev_id), 2);
    cyc(1, 4'b0000, 1, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    chk("s1_valid", 32'(bus.ev_valid), 1);
    chk("s1_pend0", 32'(bus.pend), 0);
    repeat (3) cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 0, 1, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    chk("s1_rel_stop", 32'(bus.stop_req), 0);
    chk("s1_rel_valid", 32'(bus.ev_valid), 0);
    cyc(1, 4'b1001, 0, 0, 0);
    serve(id);
    chk("s1_rr3", 32'(id), 3);
    serve(id);
    chk("s1_rr0", 32'(id), 0);

    // round robin over all requesters
    do_reset();
    cyc(1, 4'b1111, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      serve(id);
      chk("rr_all", 32'(id), 32'(i));
    end
    cyc(1, 4'b1001, 0, 0, 0);
    serve(id);
    chk("rr_9a", 32'(id), 0);
    serve(id);
    chk("rr_9b", 32'(id), 3);

    // overflow while servicing event 0
    do_reset();
    cyc(1, 4'b0001, 0, 0, 0);
    to_valid();
    cyc(1, 4'b0010, 0, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0010, 0, 0, 0);
    chk("ovf_pend", 32'(bus.pend), 32'h2);
    chk("ovf_set", 32'(bus.ovf), 32'h2);
    cyc(1, 4'b0000, 0, 0, 1);
    chk("ovf_clr", 32'(bus.ovf), 0);
    chk("ovf_keep", 32'(bus.pend), 32'h2);
    finish_grant();
    serve(id);
    chk("ovf_next", 32'(id), 1);

    // grant and re-request of the same bit in one cycle
    do_reset();
    cyc(1, 4'b0001, 0, 0, 0);
    cyc(1, 4'b0001, 0, 0, 0);
    chk("race_pend", 32'(bus.pend), 32'h1);
    chk("race_ovf", 32'(bus.ovf), 0);
    serve(id);
    chk("race_g1", 32'(id), 0);
    serve(id);
    chk("race_g2", 32'(id), 0);

    // async reset in the middle of a grant
    do_reset();
    cyc(1, 4'b0001, 0, 0, 0);
    cyc(1, 4'b1010, 0, 0, 0);
    to_valid();
    chk("mid_pend", 32'(bus.pend), 32'ha);
    do_reset();
    cyc(1, 4'b0000, 0, 1, 0);
    repeat (4) cyc(1, 4'b0000, 0, 0, 0);
    chk("mid_idle", 32'(bus.stop_req), 0);
    chk("mid_pend0", 32'(bus.pend), 0);

    // enable gating
    do_reset();
    repeat (3) cyc(0, 4'b0011, 0, 0, 0);
    chk("en_pend", 32'(bus.pend), 0);
    chk("en_stop", 32'(bus.stop_req), 0);
    cyc(1, 4'b0100, 0, 0, 0);
    chk("en_cap", 32'(bus.pend), 32'h4);
    serve(id);
    chk("en_id", 32'(id), 2);

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rq = '0;
      for (int b = 0; b < N; b++) begin
        rq[b] = ($urandom_range(3) == 0);
      end
      cyc(($urandom_range(7) != 0), rq,
          ($urandom_range(2) == 0), ($urandom_range(2) == 0),
          ($urandom_range(15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
